axilite4_arbiter_n: RTL and testbench
=====================================

AXILITE4_ARBITER_N -- requirements
Module: axilite4_arbiter_n

Interface
REQ-001 NUM_MASTERS, 4, number of master ports (2..8).
REQ-002 ADDR_W, 32, address width.
REQ-003 DATA_W, 128, data width; STRB_W = DATA_W/8.
REQ-004 RESP_W, 32, write-response message width.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  reset.
REQ-008 master_readAddr_addr/valid  in  N*ADDR_W/N  read-address request per master; master i uses slice i.
REQ-009 master_readAddr_ready  out  N  read-address accept per master.
REQ-010 master_readData_data/valid  out  N*DATA_W/N  read data per master.
REQ-011 master_readData_ready  in  N  read-data accept per master.
REQ-012 master_writeAddr_addr/valid  in  N*ADDR_W/N, plus master_writeAddr_ready  out  N.
REQ-013 master_writeData_data/strb/valid  in  N*DATA_W/N*STRB_W/N, plus master_writeData_ready  out  N.
REQ-014 master_writeResp_msg/valid  out  N*RESP_W/N, plus master_writeResp_ready  in  N.
REQ-015 slave_* ports: the same five channels as single-width mirrors, with directions inverted.
REQ-016 read_grant, write_grant  out  N  one-hot current owner, 0 when idle.

Function
REQ-017 Read and write paths SHALL arbitrate independently and may serve different masters concurrently.
REQ-018 Read FSM: R_IDLE -> R_ADDR when any readAddr_valid, registering the winner (1-cycle arbitration latency); R_ADDR -> R_DATA on slave readAddr valid&ready; R_DATA -> R_IDLE on readData valid&ready.
REQ-019 Write FSM: W_IDLE -> W_XFER when any writeAddr_valid; in W_XFER the address and data channels are forwarded independently, each with a sticky done flag; W_XFER -> W_RESP when both are done; W_RESP -> W_IDLE on writeResp valid&ready.
REQ-020 Only the owner's channel is forwarded to the slave, combinationally, in the owning state; handshake signals of a channel already done SHALL be forced 0.
REQ-021 Non-owners: ready=0, valid=0, data/msg=0; slave-side valid=0 and ready=0 outside the owning states.
REQ-022 Ownership SHALL be held until the response handshake, even if the owner drops valid mid-transaction.
REQ-023 Round robin: search from pointer ptr upward, wrapping N-1 -> 0; on transaction completion ptr = (winner+1) mod N; separate pointers for read and write.
REQ-024 Minimum occupancy is 3 cycles per read and 3 per write; a request that is already pending is granted in the cycle after the FSM returns to IDLE.

Reset
REQ-025 While rst=1 at a clock edge: FSMs SHALL go to IDLE, grants=0, ptrs=0, done flags=0, and all outputs SHALL be 0 from that edge.
REQ-026 Reset mid-transaction SHALL abandon the transaction with no response to the master.

Configuration
REQ-027 Macro AXIL_ARB_RR_EN: when defined, arbitration is round robin per REQ-023.
REQ-028 When AXIL_ARB_RR_EN is undefined: fixed priority, lowest index wins, and no pointer registers exist.

Verification (NUM_MASTERS=4, DATA_W=128)
REQ-029 Master 2 reads addr 0x100, slave returns 0xDEADBEEF -> master 2 receives 0xDEADBEEF, read_grant=4'b0100, other masters' data=0.
REQ-030 Masters 0, 1 and 3 hold readAddr_valid -> grant order 0,1,3,0 with RR; 0,0,0 without RR.
REQ-031 Master 1 reads while master 2 writes data 0xA5..A5, strb 0xFFFF -> both complete concurrently; slave sees the write; master 2 gets resp msg 0.
REQ-032 Write data valid at cycle 0, address valid at cycle 3 -> data handshake first; W_RESP entered only after the address handshake.
REQ-033 Wrap case with ptr=3 and masters 3 and 0 requesting -> grant 3, then 0.
REQ-034 rst pulsed during R_DATA -> next cycle all valids=0 and grants=0; the following request is served normally.

Source files
------------

// File: rtl/axilite4_arbiter_n_if.sv
// Five AXI-Lite channels (read addr/data, write addr/data/resp), NP ports wide.
// NP=NUM_MASTERS on the master side of the arbiter, NP=1 on the slave side.
interface axilite4_arbiter_n_if #(
  parameter int unsigned NP     = 1,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned RESP_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic [NP*ADDR_W-1:0] readAddr_addr;
  logic [NP-1:0]        readAddr_valid;
  logic [NP-1:0]        readAddr_ready;
  logic [NP*DATA_W-1:0] readData_data;
  logic [NP-1:0]        readData_valid;
  logic [NP-1:0]        readData_ready;
  logic [NP*ADDR_W-1:0] writeAddr_addr;
  logic [NP-1:0]        writeAddr_valid;
  logic [NP-1:0]        writeAddr_ready;
  logic [NP*DATA_W-1:0] writeData_data;
  logic [NP*STRB_W-1:0] writeData_strb;
  logic [NP-1:0]        writeData_valid;
  logic [NP-1:0]        writeData_ready;
  logic [NP*RESP_W-1:0] writeResp_msg;
  logic [NP-1:0]        writeResp_valid;
  logic [NP-1:0]        writeResp_ready;

  // Initiator of transactions
  modport master (
    output readAddr_addr, readAddr_valid, readData_ready,
    output writeAddr_addr, writeAddr_valid,
    output writeData_data, writeData_strb, writeData_valid, writeResp_ready,
    input  readAddr_ready, readData_data, readData_valid,
    input  writeAddr_ready, writeData_ready, writeResp_msg, writeResp_valid
  );

  // Target of transactions
  modport slave (
    input  readAddr_addr, readAddr_valid, readData_ready,
    input  writeAddr_addr, writeAddr_valid,
    input  writeData_data, writeData_strb, writeData_valid, writeResp_ready,
    output readAddr_ready, readData_data, readData_valid,
    output writeAddr_ready, writeData_ready, writeResp_msg, writeResp_valid
  );
endinterface

// File: rtl/axilite4_arbiter_n.sv
// N-to-1 AXI-Lite arbiter with independent read and write ownership FSMs.
// Define AXIL_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module axilite4_arbiter_n #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 128,
  parameter int unsigned RESP_W      = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  axilite4_arbiter_n_if.slave    mst,
  axilite4_arbiter_n_if.master   slv,
  output logic [NUM_MASTERS-1:0] read_grant,
  output logic [NUM_MASTERS-1:0] write_grant
);
  localparam int unsigned N      = NUM_MASTERS;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} rd_state_e;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_XFER = 2'd1, W_RESP = 2'd2} wr_state_e;
  typedef logic [IDX_W-1:0] idx_t;

  rd_state_e    rd_state_q, rd_state_d;
  wr_state_e    wr_state_q, wr_state_d;
  idx_t         rd_idx_q, rd_idx_d, wr_idx_q, wr_idx_d;
  logic [N-1:0] rd_gnt_q, rd_gnt_d, wr_gnt_q, wr_gnt_d;
  logic         aw_done_q, aw_done_d, w_done_q, w_done_d;
  idx_t         rd_base, wr_base;
  logic [IDX_W:0] rd_pick, wr_pick;

  logic [N-1:0]        m_ar_ready, m_r_valid, m_aw_ready, m_w_ready, m_b_valid;
  logic [N*DATA_W-1:0] m_r_data;
  logic [N*RESP_W-1:0] m_b_msg;
  logic [ADDR_W-1:0]   s_ar_addr, s_aw_addr;
  logic [DATA_W-1:0]   s_w_data;
  logic [STRB_W-1:0]   s_w_strb;
  logic                s_ar_valid, s_r_ready, s_aw_valid, s_w_valid, s_b_ready;
  logic                aw_hs, w_hs;

`ifdef AXIL_ARB_RR_EN
  idx_t rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  assign rd_base = rd_ptr_q;
  assign wr_base = wr_ptr_q;

  function automatic idx_t inc_wrap(input idx_t i);
    return (32'(i) + 1 == N) ? '0 : idx_t'(32'(i) + 1);
  endfunction
`else
  assign rd_base = '0;
  assign wr_base = '0;
`endif

  // First requester at or above base, wrapping; MSB of result flags a hit
  function automatic logic [IDX_W:0] pick(input logic [N-1:0] req, input idx_t base);
    logic [IDX_W:0] res;
    int unsigned    j;
    res = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(base) + k) % N;
      if (!res[IDX_W] && req[idx_t'(j)]) res = {1'b1, idx_t'(j)};
    end
    return res;
  endfunction

  always_comb begin
    rd_state_d = rd_state_q;
    rd_idx_d   = rd_idx_q;
    rd_gnt_d   = rd_gnt_q;
`ifdef AXIL_ARB_RR_EN
    rd_ptr_d   = rd_ptr_q;
`endif
    m_ar_ready = '0;
    m_r_valid  = '0;
    m_r_data   = '0;
    s_ar_addr  = '0;
    s_ar_valid = 1'b0;
    s_r_ready  = 1'b0;
    rd_pick    = pick(mst.readAddr_valid, rd_base);
    case (rd_state_q)
      R_IDLE: begin
        if (rd_pick[IDX_W]) begin
          rd_idx_d           = rd_pick[IDX_W-1:0];
          rd_gnt_d           = '0;
          rd_gnt_d[rd_idx_d] = 1'b1;
          rd_state_d         = R_ADDR;
        end
      end
      R_ADDR: begin
        s_ar_addr            = mst.readAddr_addr[32'(rd_idx_q)*ADDR_W +: ADDR_W];
        s_ar_valid           = mst.readAddr_valid[rd_idx_q];
        m_ar_ready[rd_idx_q] = slv.readAddr_ready;
        if (s_ar_valid && slv.readAddr_ready) rd_state_d = R_DATA;
      end
      R_DATA: begin
        m_r_data[32'(rd_idx_q)*DATA_W +: DATA_W] = slv.readData_data;
        m_r_valid[rd_idx_q] = slv.readData_valid;
        s_r_ready           = mst.readData_ready[rd_idx_q];
        if (slv.readData_valid && s_r_ready) begin
          rd_state_d = R_IDLE;
          rd_gnt_d   = '0;
`ifdef AXIL_ARB_RR_EN
          rd_ptr_d   = inc_wrap(rd_idx_q);
`endif
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Address and data phases complete independently; done flags mask repeats
  always_comb begin
    wr_state_d = wr_state_q;
    wr_idx_d   = wr_idx_q;
    wr_gnt_d   = wr_gnt_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
`ifdef AXIL_ARB_RR_EN
    wr_ptr_d   = wr_ptr_q;
`endif
    m_aw_ready = '0;
    m_w_ready  = '0;
    m_b_valid  = '0;
    m_b_msg    = '0;
    s_aw_addr  = '0;
    s_aw_valid = 1'b0;
    s_w_data   = '0;
    s_w_strb   = '0;
    s_w_valid  = 1'b0;
    s_b_ready  = 1'b0;
    aw_hs      = 1'b0;
    w_hs       = 1'b0;
    wr_pick    = pick(mst.writeAddr_valid, wr_base);
    case (wr_state_q)
      W_IDLE: begin
        if (wr_pick[IDX_W]) begin
          wr_idx_d           = wr_pick[IDX_W-1:0];
          wr_gnt_d           = '0;
          wr_gnt_d[wr_idx_d] = 1'b1;
          aw_done_d          = 1'b0;
          w_done_d           = 1'b0;
          wr_state_d         = W_XFER;
        end
      end
      W_XFER: begin
        if (!aw_done_q) begin
          s_aw_addr            = mst.writeAddr_addr[32'(wr_idx_q)*ADDR_W +: ADDR_W];
          s_aw_valid           = mst.writeAddr_valid[wr_idx_q];
          m_aw_ready[wr_idx_q] = slv.writeAddr_ready;
        end
        if (!w_done_q) begin
          s_w_data            = mst.writeData_data[32'(wr_idx_q)*DATA_W +: DATA_W];
          s_w_strb            = mst.writeData_strb[32'(wr_idx_q)*STRB_W +: STRB_W];
          s_w_valid           = mst.writeData_valid[wr_idx_q];
          m_w_ready[wr_idx_q] = slv.writeData_ready;
        end
        aw_hs     = s_aw_valid & slv.writeAddr_ready;
        w_hs      = s_w_valid & slv.writeData_ready;
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) begin
          wr_state_d = W_RESP;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
        end
      end
      W_RESP: begin
        m_b_msg[32'(wr_idx_q)*RESP_W +: RESP_W] = slv.writeResp_msg;
        m_b_valid[wr_idx_q] = slv.writeResp_valid;
        s_b_ready           = mst.writeResp_ready[wr_idx_q];
        if (slv.writeResp_valid && s_b_ready) begin
          wr_state_d = W_IDLE;
          wr_gnt_d   = '0;
`ifdef AXIL_ARB_RR_EN
          wr_ptr_d   = inc_wrap(wr_idx_q);
`endif
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= R_IDLE;
      wr_state_q <= W_IDLE;
      rd_idx_q   <= '0;
      wr_idx_q   <= '0;
      rd_gnt_q   <= '0;
      wr_gnt_q   <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
`ifdef AXIL_ARB_RR_EN
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
`endif
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      rd_idx_q   <= rd_idx_d;
      wr_idx_q   <= wr_idx_d;
      rd_gnt_q   <= rd_gnt_d;
      wr_gnt_q   <= wr_gnt_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
`ifdef AXIL_ARB_RR_EN
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
`endif
    end
  end

  assign read_grant  = rd_gnt_q;
  assign write_grant = wr_gnt_q;

  assign mst.readAddr_ready  = m_ar_ready;
  assign mst.readData_data   = m_r_data;
  assign mst.readData_valid  = m_r_valid;
  assign mst.writeAddr_ready = m_aw_ready;
  assign mst.writeData_ready = m_w_ready;
  assign mst.writeResp_msg   = m_b_msg;
  assign mst.writeResp_valid = m_b_valid;

  assign slv.readAddr_addr   = s_ar_addr;
  assign slv.readAddr_valid  = s_ar_valid;
  assign slv.readData_ready  = s_r_ready;
  assign slv.writeAddr_addr  = s_aw_addr;
  assign slv.writeAddr_valid = s_aw_valid;
  assign slv.writeData_data  = s_w_data;
  assign slv.writeData_strb  = s_w_strb;
  assign slv.writeData_valid = s_w_valid;
  assign slv.writeResp_ready = s_b_ready;
endmodule

// File: tb/tb_axilite4_arbiter_n.sv
// Bench for axilite4_arbiter_n: directed scenarios plus randomized request sets
// checked against a grant-order model. Build with +define+AXIL_ARB_RR_EN for round robin.
module tb_axilite4_arbiter_n;
  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 128;
  localparam int unsigned RW = 32;
  localparam int unsigned SW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] read_grant, write_grant;
  int checks = 0;
  int errors = 0;
  int m_rd_ptr = 0;
  int m_wr_ptr = 0;

  axilite4_arbiter_n_if #(.NP(N), .ADDR_W(AW), .DATA_W(DW), .RESP_W(RW)) mif ();
  axilite4_arbiter_n_if #(.NP(1), .ADDR_W(AW), .DATA_W(DW), .RESP_W(RW)) sif ();

  axilite4_arbiter_n #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .RESP_W(RW)) dut (
    .clk(clk), .rst(rst), .mst(mif), .slv(sif),
    .read_grant(read_grant), .write_grant(write_grant)
  );

  always #5 clk = ~clk;

  logic [AW-1:0] ar_addr [N];
  logic [AW-1:0] aw_addr [N];
  logic [DW-1:0] wd_data [N];
  logic [SW-1:0] wd_strb [N];
  logic [N-1:0]  ar_valid, aw_valid, wd_valid;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      mif.readAddr_addr[i*AW +: AW]  = ar_addr[i];
      mif.writeAddr_addr[i*AW +: AW] = aw_addr[i];
      mif.writeData_data[i*DW +: DW] = wd_data[i];
      mif.writeData_strb[i*SW +: SW] = wd_strb[i];
    end
  end
  assign mif.readAddr_valid  = ar_valid;
  assign mif.writeAddr_valid = aw_valid;
  assign mif.writeData_valid = wd_valid;
  assign mif.readData_ready  = '1;
  assign mif.writeResp_ready = '1;

  task automatic chk(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // Reference: nearest pending master at or above ptr, cyclically
  function automatic int model_pick(input logic [N-1:0] pend, input int ptr);
    int best, bestd, d;
    best = -1;
    bestd = N;
    for (int i = 0; i < N; i++) begin
      d = (i - ptr + N) % N;
      if (pend[i] && d < bestd) begin best = i; bestd = d; end
    end
    return best;
  endfunction

  function automatic int model_next(input int g);
`ifdef AXIL_ARB_RR_EN
    return (g + 1) % N;
`else
    return 0 * g;
`endif
  endfunction

  task automatic do_reset;
    rst = 1'b1;
    ar_valid = '0; aw_valid = '0; wd_valid = '0;
    sif.readAddr_ready = 1'b0; sif.readData_valid = 1'b0; sif.readData_data = '0;
    sif.writeAddr_ready = 1'b0; sif.writeData_ready = 1'b0;
    sif.writeResp_valid = 1'b0; sif.writeResp_msg = '0;
    repeat (2) tick;
    rst = 1'b0;
    m_rd_ptr = 0;
    m_wr_ptr = 0;
  endtask

  task automatic serve_read(input int g, input logic [DW-1:0] rdata, input int lat, input bit drop);
    int n;
    logic [N*DW-1:0] e;
    n = 0;
    while (read_grant == '0 && n < 20) begin tick; n++; end
    chk("rd_grant_latency", n, 1);
    chk("rd_grant", read_grant, 4'b0001 << g);
    chk("rd_slv_addr", sif.readAddr_addr, ar_addr[g]);
    chk("rd_slv_avalid", sif.readAddr_valid, 1'b1);
    sif.readAddr_ready = 1'b1;
    tick;
    sif.readAddr_ready = 1'b0;
    if (drop) ar_valid[g] = 1'b0;
    repeat (lat) begin
      #1 chk("rd_no_data_yet", mif.readData_valid, 0);
      tick;
    end
    sif.readData_data = rdata;
    sif.readData_valid = 1'b1;
    #1;
    e = '0;
    e[g*DW +: DW] = rdata;
    chk("rd_mst_data", mif.readData_data, e);
    chk("rd_mst_valid", mif.readData_valid, 4'b0001 << g);
    chk("rd_slv_ready", sif.readData_ready, 1'b1);
    tick;
    sif.readData_valid = 1'b0;
    sif.readData_data = '0;
    #1 chk("rd_grant_released", read_grant, 0);
    m_rd_ptr = model_next(g);
  endtask

  task automatic serve_write(input int g, input int aw_lat, input int w_lat, input logic [RW-1:0] msg);
    int n, c;
    bit aw_seen, w_seen, aw_hs, w_hs;
    logic [N*DW-1:0] e;
    n = 0;
    while (write_grant == '0 && n < 20) begin tick; n++; end
    chk("wr_grant_latency", n, 1);
    chk("wr_grant", write_grant, 4'b0001 << g);
    c = 0; aw_seen = 0; w_seen = 0;
    while (!(aw_seen && w_seen) && c < 20) begin
      sif.writeAddr_ready = (c >= aw_lat) && !aw_seen;
      sif.writeData_ready = (c >= w_lat) && !w_seen;
      #1;
      aw_hs = sif.writeAddr_valid && sif.writeAddr_ready;
      w_hs  = sif.writeData_valid && sif.writeData_ready;
      if (aw_hs) chk("wr_slv_addr", sif.writeAddr_addr, aw_addr[g]);
      if (w_hs) begin
        chk("wr_slv_data", sif.writeData_data, wd_data[g]);
        chk("wr_slv_strb", sif.writeData_strb, wd_strb[g]);
      end
      if (aw_seen) chk("wr_aw_forced0", {sif.writeAddr_valid, mif.writeAddr_ready}, 0);
      if (w_seen) chk("wr_w_forced0", {sif.writeData_valid, mif.writeData_ready}, 0);
      chk("wr_no_resp_in_xfer", sif.writeResp_ready, 0);
      tick;
      aw_seen |= aw_hs;
      w_seen  |= w_hs;
      c++;
    end
    chk("wr_xfer_done", {aw_seen, w_seen}, 2'b11);
    aw_valid[g] = 1'b0;
    wd_valid[g] = 1'b0;
    sif.writeAddr_ready = 1'b0;
    sif.writeData_ready = 1'b0;
    sif.writeResp_msg = msg;
    sif.writeResp_valid = 1'b1;
    #1;
    e = '0;
    e[g*RW +: RW] = msg;
    chk("wr_resp_msg", mif.writeResp_msg, e);
    chk("wr_resp_valid", mif.writeResp_valid, 4'b0001 << g);
    chk("wr_slv_bready", sif.writeResp_ready, 1'b1);
    tick;
    sif.writeResp_valid = 1'b0;
    sif.writeResp_msg = '0;
    #1 chk("wr_grant_released", write_grant, 0);
    m_wr_ptr = model_next(g);
  endtask

  initial begin
    int ord[$];
    logic [N-1:0] pend;
    int g;
    for (int i = 0; i < N; i++) begin
      ar_addr[i] = '0; aw_addr[i] = '0; wd_data[i] = '0; wd_strb[i] = '0;
    end
    do_reset();

    // Reset state
    #1;
    chk("rst_grants", {read_grant, write_grant}, 0);
    chk("rst_mst_ready", {mif.readAddr_ready, mif.writeAddr_ready, mif.writeData_ready}, 0);
    chk("rst_mst_valid", {mif.readData_valid, mif.writeResp_valid}, 0);
    chk("rst_slv_valid", {sif.readAddr_valid, sif.writeAddr_valid, sif.writeData_valid}, 0);
    chk("rst_mst_rdata", mif.readData_data, 0);

    // Single read by master 2
    ar_addr[2] = 32'h100; ar_valid[2] = 1'b1;
    serve_read(2, 128'hDEADBEEF, 0, 1);

    // Wrap: ptr now 3 under round robin
    ar_addr[3] = 32'h3000; ar_addr[0] = 32'h0040;
    ar_valid[3] = 1'b1; ar_valid[0] = 1'b1;
`ifdef AXIL_ARB_RR_EN
    serve_read(3, 128'h33, 0, 1);
    serve_read(0, 128'h44, 1, 1);
`else
    serve_read(0, 128'h44, 1, 1);
    serve_read(3, 128'h33, 0, 1);
`endif

    // Concurrent read (master 1) and write (master 2)
    ar_addr[1] = 32'h1110; ar_valid[1] = 1'b1;
    aw_addr[2] = 32'h2220; wd_data[2] = {16{8'hA5}}; wd_strb[2] = 16'hFFFF;
    aw_valid[2] = 1'b1; wd_valid[2] = 1'b1;
    fork
      serve_read(1, 128'h0123_4567_89AB_CDEF, 2, 1);
      serve_write(2, 1, 0, 32'h0);
      begin
        tick;
        #1 chk("concurrent_grants", {read_grant, write_grant}, {4'b0010, 4'b0100});
      end
    join

    // Write data early, address three cycles later
    aw_addr[1] = 32'hA0; wd_data[1] = {4{32'hCAFE_F00D}}; wd_strb[1] = 16'h0F0F;
    wd_valid[1] = 1'b1;
    repeat (3) begin
      tick;
      #1 chk("wr_wait_for_addr", {write_grant, mif.writeData_ready}, 0);
    end
    aw_valid[1] = 1'b1;
    serve_write(1, 3, 0, 32'h1234);

    // Held requests from masters 0, 1, 3 starting at ptr 0
    do_reset();
`ifdef AXIL_ARB_RR_EN
    ord = '{0, 1, 3, 0};
`else
    ord = '{0, 0, 0};
`endif
    ar_addr[0] = 32'h10; ar_addr[1] = 32'h11; ar_addr[3] = 32'h13;
    ar_valid = 4'b1011;
    foreach (ord[k]) serve_read(ord[k], 128'(32'h5000 + k), 0, 0);
    ar_valid = '0;

    // Reset during R_DATA abandons the read
    do_reset();
    ar_addr[0] = 32'h200; ar_valid[0] = 1'b1;
    tick;
    #1 chk("r34_grant", read_grant, 4'b0001);
    sif.readAddr_ready = 1'b1;
    tick;
    sif.readAddr_ready = 1'b0;
    ar_valid[0] = 1'b0;
    #1 chk("r34_in_rdata", sif.readData_ready, 1'b1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    m_rd_ptr = 0; m_wr_ptr = 0;
    #1;
    chk("r34_grants", {read_grant, write_grant}, 0);
    chk("r34_valids", {mif.readData_valid, sif.readAddr_valid, sif.readData_ready}, 0);
    ar_addr[3] = 32'h300; ar_valid[3] = 1'b1;
    serve_read(3, 128'h77, 1, 1);

    // Random read request sets
    for (int r = 0; r < 8; r++) begin
      pend = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++)
        if (pend[i]) begin ar_addr[i] = $urandom; ar_valid[i] = 1'b1; end
      while (pend != '0) begin
        g = model_pick(pend, m_rd_ptr);
        serve_read(g, {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 2), 1);
        pend[g] = 1'b0;
      end
    end

    // Random write request sets
    for (int r = 0; r < 8; r++) begin
      pend = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++)
        if (pend[i]) begin
          aw_addr[i] = $urandom;
          wd_data[i] = {$urandom, $urandom, $urandom, $urandom};
          wd_strb[i] = 16'($urandom);
          aw_valid[i] = 1'b1;
          wd_valid[i] = 1'b1;
        end
      while (pend != '0) begin
        g = model_pick(pend, m_wr_ptr);
        serve_write(g, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        pend[g] = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
